// File: rtl/pxs_str_vga_split.sv
// VGA stream sink: unpacks the 23-bit stream, blanks RGB, emits line/frame pulses and checks consistency.
// Latency DELAY cycles for every output field; there is no backpressure because the pixel clock free-runs.
module pxs_str_vga_split #(
   parameter int DELAY    = 2,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [22:0] VGAStr,
   input  logic [2:0]  Pixel,
   output logic        HSync,
   output logic        VSync,
   output logic [9:0]  XCoord,
   output logic [9:0]  YCoord,
   output logic        ActiveVideo,
   output logic [2:0]  RGB,
   output logic        LineStart,
   output logic        FrameStart,
   output logic [7:0]  FrameCount,
   output logic        CoordErr
);

   // Sync bits idle high so a cleared pipeline drives inactive negative-polarity syncs.
   localparam logic [25:0] WORD_RST = {23'h000006, 3'b000};
   localparam logic [10:0] X_LAST   = 11'(H_ACTIVE - 1);
   localparam logic [10:0] Y_LAST   = 11'(V_ACTIVE - 1);
   localparam logic [10:0] X_LIM    = 11'(H_ACTIVE);
   localparam logic [10:0] Y_LIM    = 11'(V_ACTIVE);
   localparam logic [0:0]  ST_WAIT  = 1'b0;
   localparam logic [0:0]  ST_CHECK = 1'b1;

   logic [25:0] entry;

   generate
      if (DELAY == 1) begin : g_direct
         assign entry = {VGAStr, Pixel};
      end else begin : g_mid
         logic [25:0] mid [DELAY-1];
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < DELAY - 1; i++) mid[i] <= WORD_RST;
            end else begin
               mid[0] <= {VGAStr, Pixel};
               for (int i = 1; i < DELAY - 1; i++) mid[i] <= mid[i-1];
            end
         end
         assign entry = mid[DELAY-2];
      end
   endgenerate

   // Decode the word entering the last stage so pulses and RGB register alongside it.
   logic       e_act, e_ls, e_fs;
   logic [9:0] e_x, e_y;
   assign e_act = entry[3];
   assign e_y   = entry[15:6];
   assign e_x   = entry[25:16];
   assign e_ls  = e_act & (e_x == 10'd0);
   assign e_fs  = e_ls & (e_y == 10'd0);

   logic [22:0] str_q;
   logic [2:0]  rgb_q;
   logic        ls_q, fs_q;
   logic [7:0]  fcnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         str_q  <= WORD_RST[25:3];
         rgb_q  <= 3'b000;
         ls_q   <= 1'b0;
         fs_q   <= 1'b0;
         fcnt_q <= 8'd0;
      end else begin
         str_q  <= entry[25:3];
         rgb_q  <= e_act ? entry[2:0] : 3'b000;
         ls_q   <= e_ls;
         fs_q   <= e_fs;
         if (e_fs) fcnt_q <= fcnt_q + 8'd1;
      end
   end

   logic       o_act;
   logic [9:0] o_x, o_y;
   assign o_act = str_q[0];
   assign o_y   = str_q[12:3];
   assign o_x   = str_q[22:13];

   logic [0:0]  state_q;
   logic        prev_act_q, err_q, viol;
   logic [9:0]  prev_x_q, last_y_q;
   logic [10:0] x_w, y_w, px_w, ly_w, px_inc, ly_inc;

   // Widened to 11 bits so an increment of 1023 cannot wrap back to 0.
   assign x_w    = {1'b0, o_x};
   assign y_w    = {1'b0, o_y};
   assign px_w   = {1'b0, prev_x_q};
   assign ly_w   = {1'b0, last_y_q};
   assign px_inc = px_w + 11'd1;
   assign ly_inc = ly_w + 11'd1;

   assign viol = (prev_act_q & o_act & (x_w != px_inc))
               | (!prev_act_q & o_act & (x_w != 11'd0))
               | (prev_act_q & !o_act & (px_w != X_LAST))
               | (ls_q & (y_w != 11'd0) & (y_w != ly_inc))
               | (fs_q & (ly_w != Y_LAST))
               | (o_act & ((x_w >= X_LIM) | (y_w >= Y_LIM)));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_WAIT;
         prev_act_q <= 1'b0;
         prev_x_q   <= 10'd0;
         last_y_q   <= 10'd0;
         err_q      <= 1'b0;
      end else begin
         prev_act_q <= o_act;
         prev_x_q   <= o_x;
         case (state_q)
            ST_WAIT: begin
               if (fs_q) begin
                  state_q  <= ST_CHECK;
                  last_y_q <= 10'd0;
               end
            end
            ST_CHECK: begin
               if (ls_q) last_y_q <= o_y;
               if (viol) err_q <= 1'b1;
            end
            default: state_q <= ST_WAIT;
         endcase
      end
   end

   assign HSync       = str_q[2];
   assign VSync       = str_q[1];
   assign XCoord      = o_x;
   assign YCoord      = o_y;
   assign ActiveVideo = o_act;
   assign RGB         = rgb_q;
   assign LineStart   = ls_q;
   assign FrameStart  = fs_q;
   assign FrameCount  = fcnt_q;
   assign CoordErr    = err_q;

endmodule

// File: tb/tb_pxs_str_vga_split.sv
// Directed bench: small-raster instance (DELAY=2, 4x2) and a mid-size instance (DELAY=3, 101x204).
module tb_pxs_str_vga_split;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [22:0] a_str = '0, b_str = '0;
   logic [2:0]  a_pix = '0, b_pix = '0;

   logic       a_hs, a_vs, a_act, a_ls_o, a_fs_o, a_err;
   logic [9:0] a_x, a_y;
   logic [2:0] a_rgb;
   logic [7:0] a_fc;
   logic       b_hs, b_vs, b_act, b_ls_o, b_fs_o, b_err;
   logic [9:0] b_x, b_y;
   logic [2:0] b_rgb;
   logic [7:0] b_fc;

   always #5 clk = ~clk;

   pxs_str_vga_split #(.DELAY(2), .H_ACTIVE(4), .V_ACTIVE(2)) dut_a (
      .clk(clk), .reset(reset), .VGAStr(a_str), .Pixel(a_pix),
      .HSync(a_hs), .VSync(a_vs), .XCoord(a_x), .YCoord(a_y),
      .ActiveVideo(a_act), .RGB(a_rgb), .LineStart(a_ls_o),
      .FrameStart(a_fs_o), .FrameCount(a_fc), .CoordErr(a_err)
   );

   pxs_str_vga_split #(.DELAY(3), .H_ACTIVE(101), .V_ACTIVE(204)) dut_b (
      .clk(clk), .reset(reset), .VGAStr(b_str), .Pixel(b_pix),
      .HSync(b_hs), .VSync(b_vs), .XCoord(b_x), .YCoord(b_y),
      .ActiveVideo(b_act), .RGB(b_rgb), .LineStart(b_ls_o),
      .FrameStart(b_fs_o), .FrameCount(b_fc), .CoordErr(b_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [22:0] mkw(input logic act, input logic hs, input logic vs,
                                       input logic [9:0] x, input logic [9:0] y);
      return {x, y, hs, vs, act};
   endfunction

   function automatic logic [2:0] pf(input logic [9:0] x, input logic [9:0] y);
      logic [9:0] t;
      t = x ^ y;
      return t[2:0];
   endfunction

   // The unselected instance is fed idle zero words.
   task automatic send(input bit sel, input logic [22:0] w, input logic [2:0] p);
      if (sel) begin
         b_str = w; b_pix = p; a_str = '0; a_pix = '0;
      end else begin
         a_str = w; a_pix = p; b_str = '0; b_pix = '0;
      end
      step();
   endtask

   task automatic send_line(input bit sel, input int y, input int x0, input int x1);
      for (int x = x0; x <= x1; x++)
         send(sel, mkw(1'b1, 1'b0, 1'b0, 10'(x), 10'(y)), pf(10'(x), 10'(y)));
      send(sel, mkw(1'b0, 1'b1, 1'b0, 10'd0, 10'(y)), 3'b111);
   endtask

   task automatic send_vbl(input bit sel, input int n);
      for (int i = 0; i < n; i++)
         send(sel, mkw(1'b0, 1'b0, 1'b1, 10'd0, 10'd0), 3'b111);
   endtask

   task automatic send_frame(input bit sel, input int h, input int v);
      for (int y = 0; y < v; y++) send_line(sel, y, 0, h - 1);
      send_vbl(sel, h + 1);
   endtask

   int a_ls = 0, a_fs = 0, b_ls = 0, b_fs = 0, bad_al = 0, bad_rgb = 0;
   bit mon_en = 1'b0;

   always @(negedge clk) begin
      if (a_ls_o) a_ls++;
      if (a_fs_o) a_fs++;
      if (b_ls_o) b_ls++;
      if (b_fs_o) b_fs++;
      if (a_fs_o && !(a_act && a_x == 10'd0 && a_y == 10'd0)) bad_al++;
      if (b_fs_o && !(b_act && b_x == 10'd0 && b_y == 10'd0)) bad_al++;
      if (a_ls_o !== (a_act && a_x == 10'd0)) bad_al++;
      if (b_ls_o !== (b_act && b_x == 10'd0)) bad_al++;
      if (mon_en) begin
         if (a_rgb !== (a_act ? pf(a_x, a_y) : 3'b000)) bad_rgb++;
         if (b_rgb !== (b_act ? pf(b_x, b_y) : 3'b000)) bad_rgb++;
      end
   end

   int s_ls, s_fs;

   initial begin
      // Reset held with idle words whose syncs are 0.
      reset = 1'b1;
      repeat (3) send(1'b0, 23'd0, 3'd0);
      chk("rst_hs", a_hs, 1);
      chk("rst_vs", a_vs, 1);
      chk("rst_x", a_x, 0);
      chk("rst_y", a_y, 0);
      chk("rst_act", a_act, 0);
      chk("rst_rgb", a_rgb, 0);
      chk("rst_ls", a_ls_o, 0);
      chk("rst_fs", a_fs_o, 0);
      chk("rst_fc", a_fc, 0);
      chk("rst_err", a_err, 0);
      chk("rst_b_hs", b_hs, 1);
      chk("rst_b_vs", b_vs, 1);

      reset = 1'b0;
      send(1'b0, 23'd0, 3'd0);
      chk("lat_a_hs_c1", a_hs, 1);
      send(1'b0, 23'd0, 3'd0);
      chk("lat_a_hs_c2", a_hs, 0);
      chk("lat_a_vs_c2", a_vs, 0);
      chk("lat_b_hs_c2", b_hs, 1);
      send(1'b0, 23'd0, 3'd0);
      chk("lat_b_hs_c3", b_hs, 0);

      // Single active pixel then a blanked word carrying 111.
      send(1'b0, mkw(1'b1, 1'b0, 1'b0, 10'd5, 10'd7), 3'b101);
      send(1'b0, mkw(1'b0, 1'b0, 1'b0, 10'd0, 10'd0), 3'b111);
      chk("px_rgb", a_rgb, 3'b101);
      chk("px_x", a_x, 5);
      chk("px_y", a_y, 7);
      chk("px_act", a_act, 1);
      chk("px_ls", a_ls_o, 0);
      send(1'b0, 23'd0, 3'd0);
      chk("blank_rgb", a_rgb, 3'b000);

      mon_en = 1'b1;
      s_ls = a_ls;
      s_fs = a_fs;
      send_frame(1'b0, 4, 2);
      chk("fc_1", a_fc, 1);
      send_frame(1'b0, 4, 2);
      chk("fs_pulses", a_fs - s_fs, 2);
      chk("ls_pulses", a_ls - s_ls, 4);
      chk("fc_2", a_fc, 2);
      chk("err_legal", a_err, 0);

      repeat (253) send_frame(1'b0, 4, 2);
      chk("fc_255", a_fc, 255);
      send_frame(1'b0, 4, 2);
      chk("fc_wrap", a_fc, 0);
      chk("err_after_wrap", a_err, 0);

      // Stream joins mid-frame at (100,200); WAIT must ignore the partial frame.
      send_line(1'b1, 200, 100, 100);
      for (int y = 201; y <= 203; y++) send_line(1'b1, y, 0, 100);
      send_vbl(1'b1, 102);
      chk("mid_err_wait", b_err, 0);
      chk("mid_fc_wait", b_fc, 0);
      s_fs = b_fs;
      for (int y = 0; y <= 201; y++) send_line(1'b1, y, 0, 100);
      chk("mid_fs_once", b_fs - s_fs, 1);
      chk("mid_err_check", b_err, 0);
      send_line(1'b1, 203, 0, 100);
      chk("yskip_err", b_err, 1);
      chk("mid_fc", b_fc, 1);

      // Reset while a frame-start word is still in flight: no pulse may emerge.
      s_fs = a_fs;
      send(1'b0, mkw(1'b1, 1'b0, 1'b0, 10'd0, 10'd0), pf(10'd0, 10'd0));
      reset = 1'b1;
      repeat (3) send(1'b0, 23'd0, 3'd0);
      chk("rst_flight_fs", a_fs - s_fs, 0);
      chk("rst_clears_err", b_err, 0);
      reset = 1'b0;
      send(1'b0, 23'd0, 3'd0);

      // X jumps 8 -> 10 once the checker is armed.
      for (int x = 0; x <= 8; x++)
         send(1'b1, mkw(1'b1, 1'b0, 1'b0, 10'(x), 10'd0), pf(10'(x), 10'd0));
      send(1'b1, mkw(1'b1, 1'b0, 1'b0, 10'd10, 10'd0), pf(10'd10, 10'd0));
      send(1'b1, mkw(1'b0, 1'b1, 1'b0, 10'd0, 10'd0), 3'b111);
      send(1'b1, mkw(1'b0, 1'b1, 1'b0, 10'd0, 10'd0), 3'b111);
      chk("xjump_err_early", b_err, 0);
      send(1'b1, mkw(1'b0, 1'b1, 1'b0, 10'd0, 10'd0), 3'b111);
      chk("xjump_err", b_err, 1);
      send_frame(1'b1, 101, 204);
      chk("err_sticky", b_err, 1);
      chk("b_fc_2", b_fc, 2);

      chk("pulse_align", bad_al, 0);
      chk("rgb_blank", bad_rgb, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
